// File: rtl/mem_access_stage_pkg.sv
// rtl/mem_access_stage_pkg.sv - encodings, FSM states and MEM/WB record type for the MEM stage
//   Shared by mem_access_stage and mem_access_stage_align; no ports.
package mem_access_stage_pkg;

  // MemRW_pype2 encodings
  localparam logic [1:0] MEMRW_NONE  = 2'b00;
  localparam logic [1:0] MEMRW_STORE = 2'b10;

  // MemtoReg_pype2 writeback select
  localparam logic [1:0] WBSEL_ALU = 2'b00;
  localparam logic [1:0] WBSEL_MEM = 2'b01;
  localparam logic [1:0] WBSEL_PC4 = 2'b10;

  // dsize_pype2 access size
  localparam logic [1:0] DSIZE_B = 2'b00;
  localparam logic [1:0] DSIZE_H = 2'b01;
  localparam logic [1:0] DSIZE_W = 2'b10;

  // Opcodes that can redirect fetch
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  // Load funct3
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Branch funct3
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  wreg;
    logic        regwrite;
    logic [31:0] instr;
  } memwb_t;

endpackage

// File: rtl/mem_access_stage_align.sv
// rtl/mem_access_stage_align.sv - byte enables, store lane replication, load shift/extend, misalignment
//   i_is_mem     : a load or store is requested
//   i_addr_lo    : address bits [1:0]
//   i_dsize      : access size
//   i_funct3     : load funct3 (selects sign/zero extension)
//   i_wdata      : store data, zero-extended to access size
//   i_rdata      : raw memory read word
//   o_be         : byte enables
//   o_wdata      : lane-replicated store data
//   o_load_data  : aligned and extended load result
//   o_misalign   : access crosses its natural alignment
module mem_access_stage_align
  import mem_access_stage_pkg::*;
(
  input  logic        i_is_mem,
  input  logic [1:0]  i_addr_lo,
  input  logic [1:0]  i_dsize,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_load_data,
  output logic        o_misalign
);

  logic [4:0]  w_shamt;
  logic [31:0] w_shifted;
  logic        w_is_half;
  logic        w_is_word;

  assign w_shamt   = {i_addr_lo, 3'b000};
  assign w_shifted = i_rdata >> w_shamt;
  assign w_is_half = (i_dsize == DSIZE_H);
  // The unused size code 11 is handled as a word access.
  assign w_is_word = !(i_dsize == DSIZE_B || w_is_half);

  assign o_misalign = i_is_mem &&
                      ((w_is_half && i_addr_lo[0]) || (w_is_word && (i_addr_lo != 2'b00)));

  always_comb begin
    o_be    = 4'b1111;
    o_wdata = i_wdata;
    case (i_dsize)
      DSIZE_B: begin
        o_be    = 4'b0001 << i_addr_lo;
        o_wdata = {4{i_wdata[7:0]}};
      end
      DSIZE_H: begin
        o_be    = 4'b0011 << i_addr_lo;
        o_wdata = {2{i_wdata[15:0]}};
      end
      DSIZE_W: begin
        o_be    = 4'b1111;
        o_wdata = i_wdata;
      end
      default: begin
        o_be    = 4'b1111;
        o_wdata = i_wdata;
      end
    endcase
  end

  always_comb begin
    o_load_data = w_shifted;
    case (i_funct3)
      F3_LB:   o_load_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
      F3_LH:   o_load_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
      F3_LBU:  o_load_data = {24'd0, w_shifted[7:0]};
      F3_LHU:  o_load_data = {16'd0, w_shifted[15:0]};
      F3_LW:   o_load_data = w_shifted;
      default: o_load_data = w_shifted;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - RV32I MEM stage: data-memory handshake, branch resolution, MEM/WB register
//   i_clk, i_rst          : clock, synchronous active-high reset
//   i_keep, i_nop         : MEM/WB freeze and flush
//   i_*_pype2             : EX/MEM pipeline register fields
//   o_dmem_*, i_dmem_*    : data-memory req/ack port
//   o_stall_mem           : freezes IF/ID/EX while an access is outstanding
//   o_branch_taken/target : fetch redirect
//   o_misalign, o_mem_fault : misaligned access, access timeout pulse
//   o_*_pype3             : MEM/WB pipeline register fields
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int WAIT_MAX = 15
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_keep,
  input  logic        i_nop,
  input  logic [31:0] i_ALU_co_pype,
  input  logic [31:0] i_read_data2_pype2,
  input  logic [31:0] i_PCBranch_pype2,
  input  logic [31:0] i_PCp4_pype2,
  input  logic [4:0]  i_WReg_pype2,
  input  logic        i_RegWrite_pype2,
  input  logic [1:0]  i_MemtoReg_pype2,
  input  logic [1:0]  i_MemRW_pype2,
  input  logic [1:0]  i_dsize_pype2,
  input  logic [31:0] i_Instraction_pype2,
  output logic        o_dmem_req,
  output logic        o_dmem_we,
  output logic [31:0] o_dmem_addr,
  output logic [3:0]  o_dmem_be,
  output logic [31:0] o_dmem_wdata,
  input  logic [31:0] i_dmem_rdata,
  input  logic        i_dmem_ack,
  output logic        o_stall_mem,
  output logic        o_branch_taken,
  output logic [31:0] o_branch_target,
  output logic        o_misalign,
  output logic        o_mem_fault,
  output logic [31:0] o_WB_data_pype3,
  output logic [4:0]  o_WReg_pype3,
  output logic        o_RegWrite_pype3,
  output logic [31:0] o_Instraction_pype3
);

  localparam int CW = $clog2(WAIT_MAX + 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(WAIT_MAX);

  state_e        r_state;
  logic [CW-1:0] r_wait_cnt;
  memwb_t        r_memwb;
  memwb_t        r_buf;

  logic          w_is_mem;
  logic          w_memop;
  logic          w_misalign;
  logic [31:0]   w_load_data;
  logic [31:0]   w_wb_data;
  logic          w_stall;
  logic          w_timeout;
  logic          w_cond;
  logic          w_taken;
  logic [6:0]    w_opc;
  logic [2:0]    w_f3;
  memwb_t        w_new;

  assign w_opc    = i_Instraction_pype2[6:0];
  assign w_f3     = i_Instraction_pype2[14:12];
  assign w_is_mem = (i_MemRW_pype2 != MEMRW_NONE);
  assign w_memop  = w_is_mem && !w_misalign;

  mem_access_stage_align u_align (
    .i_is_mem    (w_is_mem),
    .i_addr_lo   (i_ALU_co_pype[1:0]),
    .i_dsize     (i_dsize_pype2),
    .i_funct3    (w_f3),
    .i_wdata     (i_read_data2_pype2),
    .i_rdata     (i_dmem_rdata),
    .o_be        (o_dmem_be),
    .o_wdata     (o_dmem_wdata),
    .o_load_data (w_load_data),
    .o_misalign  (w_misalign)
  );

  // Request is combinational so a reset mid-access drops it in the same cycle.
  always_comb begin
    o_dmem_req = 1'b0;
    case (r_state)
      ST_IDLE: o_dmem_req = w_memop;
      ST_WAIT: o_dmem_req = 1'b1;
      default: o_dmem_req = 1'b0;
    endcase
    if (i_rst) o_dmem_req = 1'b0;
  end

  assign o_dmem_we   = o_dmem_req && (i_MemRW_pype2 == MEMRW_STORE);
  assign o_dmem_addr = {i_ALU_co_pype[31:2], 2'b00};
  assign o_misalign  = w_misalign;

  assign w_stall = !i_rst &&
                   ((w_memop && !i_dmem_ack && (r_state != ST_HOLD)) || (r_state == ST_HOLD));
  assign o_stall_mem = w_stall;

  assign w_timeout   = !i_rst && (r_state == ST_WAIT) && !i_dmem_ack && (r_wait_cnt == WAIT_LAST);
  assign o_mem_fault = w_timeout;

  always_comb begin
    case (i_MemtoReg_pype2)
      WBSEL_ALU: w_wb_data = i_ALU_co_pype;
      WBSEL_MEM: w_wb_data = w_load_data;
      WBSEL_PC4: w_wb_data = i_PCp4_pype2;
      default:   w_wb_data = i_ALU_co_pype;
    endcase
  end

  assign w_new = '{data:     w_wb_data,
                   wreg:     i_WReg_pype2,
                   regwrite: i_RegWrite_pype2 && !w_misalign,
                   instr:    i_Instraction_pype2};

  // The execute stage leaves the comparison outcome in ALU bit 0 for the
  // relational branches and the full difference for BEQ/BNE.
  always_comb begin
    case (w_f3)
      F3_BEQ:  w_cond = (i_ALU_co_pype == 32'd0);
      F3_BNE:  w_cond = (i_ALU_co_pype != 32'd0);
      F3_BLT:  w_cond = i_ALU_co_pype[0];
      F3_BLTU: w_cond = i_ALU_co_pype[0];
      F3_BGE:  w_cond = !i_ALU_co_pype[0];
      F3_BGEU: w_cond = !i_ALU_co_pype[0];
      default: w_cond = 1'b0;
    endcase
    w_taken = 1'b0;
    if (w_opc == OPC_BRANCH) w_taken = w_cond;
    else if (w_opc == OPC_JAL || w_opc == OPC_JALR) w_taken = 1'b1;
    if (i_rst || w_stall) w_taken = 1'b0;
  end

  assign o_branch_taken  = w_taken;
  assign o_branch_target = i_PCBranch_pype2;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_wait_cnt <= '0;
      r_memwb    <= '0;
      r_buf      <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_memop) begin
            if (i_dmem_ack) begin
              if (i_keep) begin
                r_buf   <= w_new;
                r_state <= ST_HOLD;
              end
            end else begin
              r_state    <= ST_WAIT;
              r_wait_cnt <= CW'(1);
            end
          end
        end
        ST_WAIT: begin
          if (i_dmem_ack) begin
            r_wait_cnt <= '0;
            if (i_keep) begin
              r_buf   <= w_new;
              r_state <= ST_HOLD;
            end else begin
              r_state <= ST_IDLE;
            end
          end else if (w_timeout) begin
            r_wait_cnt <= '0;
            r_state    <= ST_IDLE;
          end else begin
            r_wait_cnt <= r_wait_cnt + CW'(1);
          end
        end
        ST_HOLD: begin
          // The access already completed; only wait for the freeze to lift.
          if (!i_keep) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase

      // Timeout is checked before the stall hold: the failed access is
      // retired as a bubble even though the stall is still asserted.
      if (i_keep) begin
        r_memwb <= r_memwb;
      end else if (r_state == ST_HOLD) begin
        r_memwb <= i_nop ? '0 : r_buf;
      end else if (w_timeout) begin
        r_memwb <= '0;
      end else if (w_stall) begin
        r_memwb <= r_memwb;
      end else if (i_nop) begin
        r_memwb <= '0;
      end else begin
        r_memwb <= w_new;
      end
    end
  end

  assign o_WB_data_pype3     = r_memwb.data;
  assign o_WReg_pype3        = r_memwb.wreg;
  assign o_RegWrite_pype3    = r_memwb.regwrite;
  assign o_Instraction_pype3 = r_memwb.instr;

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - scoreboard bench for mem_access_stage
module tb_mem_access_stage;
  import mem_access_stage_pkg::*;

  localparam int WAIT_MAX = 15;
  localparam logic [1:0] MR_LOAD   = 2'b01;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_ALU    = 7'b0110011;
  localparam logic [31:0] PCB      = 32'h0000_4A00;
  localparam logic [31:0] PCP4     = 32'h0000_0104;

  logic        i_clk = 1'b0;
  logic        i_rst, i_keep, i_nop;
  logic [31:0] i_ALU_co_pype, i_read_data2_pype2, i_PCBranch_pype2, i_PCp4_pype2;
  logic [4:0]  i_WReg_pype2;
  logic        i_RegWrite_pype2;
  logic [1:0]  i_MemtoReg_pype2, i_MemRW_pype2, i_dsize_pype2;
  logic [31:0] i_Instraction_pype2;
  logic        o_dmem_req, o_dmem_we;
  logic [31:0] o_dmem_addr, o_dmem_wdata;
  logic [3:0]  o_dmem_be;
  logic [31:0] i_dmem_rdata;
  logic        i_dmem_ack;
  logic        o_stall_mem, o_branch_taken, o_misalign, o_mem_fault;
  logic [31:0] o_branch_target, o_WB_data_pype3, o_Instraction_pype3;
  logic [4:0]  o_WReg_pype3;
  logic        o_RegWrite_pype3;

  always #5 i_clk = ~i_clk;

  mem_access_stage #(.WAIT_MAX(WAIT_MAX)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_keep(i_keep), .i_nop(i_nop),
    .i_ALU_co_pype(i_ALU_co_pype), .i_read_data2_pype2(i_read_data2_pype2),
    .i_PCBranch_pype2(i_PCBranch_pype2), .i_PCp4_pype2(i_PCp4_pype2),
    .i_WReg_pype2(i_WReg_pype2), .i_RegWrite_pype2(i_RegWrite_pype2),
    .i_MemtoReg_pype2(i_MemtoReg_pype2), .i_MemRW_pype2(i_MemRW_pype2),
    .i_dsize_pype2(i_dsize_pype2), .i_Instraction_pype2(i_Instraction_pype2),
    .o_dmem_req(o_dmem_req), .o_dmem_we(o_dmem_we), .o_dmem_addr(o_dmem_addr),
    .o_dmem_be(o_dmem_be), .o_dmem_wdata(o_dmem_wdata),
    .i_dmem_rdata(i_dmem_rdata), .i_dmem_ack(i_dmem_ack),
    .o_stall_mem(o_stall_mem), .o_branch_taken(o_branch_taken),
    .o_branch_target(o_branch_target), .o_misalign(o_misalign), .o_mem_fault(o_mem_fault),
    .o_WB_data_pype3(o_WB_data_pype3), .o_WReg_pype3(o_WReg_pype3),
    .o_RegWrite_pype3(o_RegWrite_pype3), .o_Instraction_pype3(o_Instraction_pype3)
  );

  typedef struct {
    string       tag;
    logic [31:0] data;
    logic [4:0]  wreg;
    logic        rw;
    logic [31:0] instr;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [6:0] opc, input logic [2:0] f3);
    return {17'd0, f3, 5'd0, opc};
  endfunction

  task automatic drive(input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] wreg,
                       input logic rw, input logic [1:0] m2r, input logic [1:0] mrw,
                       input logic [1:0] dsz, input logic [31:0] instr);
    i_ALU_co_pype       = alu;
    i_read_data2_pype2  = wd;
    i_WReg_pype2        = wreg;
    i_RegWrite_pype2    = rw;
    i_MemtoReg_pype2    = m2r;
    i_MemRW_pype2       = mrw;
    i_dsize_pype2       = dsz;
    i_Instraction_pype2 = instr;
  endtask

  task automatic push_exp(input string tag, input logic [31:0] data, input logic [4:0] wreg,
                          input logic rw, input logic [31:0] instr);
    exp_t e;
    e.tag = tag; e.data = data; e.wreg = wreg; e.rw = rw; e.instr = instr;
    sb_q.push_back(e);
  endtask

  task automatic sb_check(input string tag);
    exp_t e;
    check_eq({tag, ".sb_depth"}, 32'(sb_q.size()), 32'd1);
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check_eq({e.tag, ".wb_data"}, o_WB_data_pype3, e.data);
      check_eq({e.tag, ".wreg"}, 32'(o_WReg_pype3), 32'(e.wreg));
      check_eq({e.tag, ".regwrite"}, 32'(o_RegWrite_pype3), 32'(e.rw));
      check_eq({e.tag, ".instr"}, o_Instraction_pype3, e.instr);
    end
  endtask

  // Called at posedge+1 with the instruction already driven; acks after
  // ack_lat cycles and returns at posedge+1 after MEM/WB has captured.
  task automatic run_op(input string tag, input int ack_lat, input logic [31:0] rdata,
                        input int exp_stall);
    int cyc;
    int stalls;
    bit done;
    cyc = 0; stalls = 0; done = 1'b0;
    while (!done && cyc < 40) begin
      i_dmem_ack   = (cyc == ack_lat);
      i_dmem_rdata = (cyc == ack_lat) ? rdata : 32'hDEAD_BEEF;
      #2;
      if (o_stall_mem) stalls++;
      done = !o_stall_mem;
      @(posedge i_clk); #1;
      cyc++;
    end
    i_dmem_ack = 1'b0;
    check_eq({tag, ".done"}, 32'(done), 32'd1);
    check_eq({tag, ".stall_cycles"}, 32'(stalls), 32'(exp_stall));
    sb_check(tag);
  endtask

  initial begin
    int hs;
    int nfault;
    int fault_cyc;
    i_rst = 1'b1; i_keep = 1'b0; i_nop = 1'b0;
    i_dmem_ack = 1'b0; i_dmem_rdata = 32'd0;
    i_PCBranch_pype2 = PCB; i_PCp4_pype2 = PCP4;
    drive(32'h1000, 32'd0, 5'd3, 1'b1, WBSEL_MEM, MR_LOAD, DSIZE_W, mk(OP_LOAD, F3_LW));
    repeat (2) @(posedge i_clk);
    #3;
    check_eq("reset.req", 32'(o_dmem_req), 32'd0);
    check_eq("reset.stall", 32'(o_stall_mem), 32'd0);
    check_eq("reset.wb_data", o_WB_data_pype3, 32'd0);
    check_eq("reset.regwrite", 32'(o_RegWrite_pype3), 32'd0);
    check_eq("reset.instr", o_Instraction_pype3, 32'd0);
    @(posedge i_clk); #1;
    i_rst = 1'b0;

    // Plain ALU result
    drive(32'h0000_1234, 32'd0, 5'd1, 1'b1, WBSEL_ALU, MEMRW_NONE, DSIZE_W, mk(OP_ALU, 3'b000));
    push_exp("alu", 32'h0000_1234, 5'd1, 1'b1, mk(OP_ALU, 3'b000));
    run_op("alu", 0, 32'd0, 0);

    // SB at 0x1003, zero-wait
    drive(32'h0000_1003, 32'h0000_00AB, 5'd0, 1'b0, WBSEL_ALU, MEMRW_STORE, DSIZE_B, mk(OP_STORE, 3'b000));
    push_exp("sb", 32'h0000_1003, 5'd0, 1'b0, mk(OP_STORE, 3'b000));
    #2;
    check_eq("sb.be", 32'(o_dmem_be), 32'h8);
    check_eq("sb.wdata", o_dmem_wdata, 32'hABAB_ABAB);
    check_eq("sb.addr", o_dmem_addr, 32'h0000_1000);
    check_eq("sb.we", 32'(o_dmem_we), 32'd1);
    check_eq("sb.req", 32'(o_dmem_req), 32'd1);
    run_op("sb", 0, 32'd0, 0);

    // LB at 0x1002 with three wait cycles
    drive(32'h0000_1002, 32'd0, 5'd5, 1'b1, WBSEL_MEM, MR_LOAD, DSIZE_B, mk(OP_LOAD, F3_LB));
    push_exp("lb_wait", 32'hFFFF_FF80, 5'd5, 1'b1, mk(OP_LOAD, F3_LB));
    run_op("lb_wait", 3, 32'h0080_0000, 3);

    // LBU same address, zero-wait
    drive(32'h0000_1002, 32'd0, 5'd6, 1'b1, WBSEL_MEM, MR_LOAD, DSIZE_B, mk(OP_LOAD, F3_LBU));
    push_exp("lbu", 32'h0000_0080, 5'd6, 1'b1, mk(OP_LOAD, F3_LBU));
    run_op("lbu", 0, 32'h0080_0000, 0);

    // LH upper half, one wait cycle
    drive(32'h0000_1002, 32'd0, 5'd8, 1'b1, WBSEL_MEM, MR_LOAD, DSIZE_H, mk(OP_LOAD, F3_LH));
    push_exp("lh", 32'hFFFF_8001, 5'd8, 1'b1, mk(OP_LOAD, F3_LH));
    #2;
    check_eq("lh.be", 32'(o_dmem_be), 32'hC);
    run_op("lh", 1, 32'h8001_0000, 1);

    // Misaligned LW is suppressed
    drive(32'h0000_1001, 32'd0, 5'd4, 1'b1, WBSEL_MEM, MR_LOAD, DSIZE_W, mk(OP_LOAD, F3_LW));
    push_exp("lw_mis", 32'd0, 5'd4, 1'b0, mk(OP_LOAD, F3_LW));
    #2;
    check_eq("lw_mis.misalign", 32'(o_misalign), 32'd1);
    check_eq("lw_mis.req", 32'(o_dmem_req), 32'd0);
    run_op("lw_mis", 0, 32'd0, 0);

    // Branches and JAL
    drive(32'd5, 32'd0, 5'd0, 1'b0, WBSEL_ALU, MEMRW_NONE, DSIZE_W, mk(OPC_BRANCH, F3_BNE));
    push_exp("bne", 32'd5, 5'd0, 1'b0, mk(OPC_BRANCH, F3_BNE));
    #2;
    check_eq("bne.taken", 32'(o_branch_taken), 32'd1);
    check_eq("bne.target", o_branch_target, PCB);
    run_op("bne", 0, 32'd0, 0);

    drive(32'd1, 32'd0, 5'd0, 1'b0, WBSEL_ALU, MEMRW_NONE, DSIZE_W, mk(OPC_BRANCH, F3_BGE));
    push_exp("bge", 32'd1, 5'd0, 1'b0, mk(OPC_BRANCH, F3_BGE));
    #2;
    check_eq("bge.taken", 32'(o_branch_taken), 32'd0);
    run_op("bge", 0, 32'd0, 0);

    drive(32'd0, 32'd0, 5'd0, 1'b0, WBSEL_ALU, MEMRW_NONE, DSIZE_W, mk(OPC_BRANCH, F3_BEQ));
    push_exp("beq", 32'd0, 5'd0, 1'b0, mk(OPC_BRANCH, F3_BEQ));
    #2;
    check_eq("beq.taken", 32'(o_branch_taken), 32'd1);
    run_op("beq", 0, 32'd0, 0);

    drive(32'h0000_0400, 32'd0, 5'd1, 1'b1, WBSEL_PC4, MEMRW_NONE, DSIZE_W, mk(OPC_JAL, 3'b000));
    push_exp("jal", PCP4, 5'd1, 1'b1, mk(OPC_JAL, 3'b000));
    #2;
    check_eq("jal.taken", 32'(o_branch_taken), 32'd1);
    run_op("jal", 0, 32'd0, 0);

    // Flush of a non-memory op, then flush during an outstanding load
    i_nop = 1'b1;
    drive(32'h0000_0999, 32'd0, 5'd2, 1'b1, WBSEL_ALU, MEMRW_NONE, DSIZE_W, mk(OP_ALU, 3'b000));
    push_exp("nop_alu", 32'd0, 5'd0, 1'b0, 32'd0);
    run_op("nop_alu", 0, 32'd0, 0);
    drive(32'h0000_1002, 32'd0, 5'd6, 1'b1, WBSEL_MEM, MR_LOAD, DSIZE_B, mk(OP_LOAD, F3_LBU));
    push_exp("nop_wait", 32'd0, 5'd0, 1'b0, 32'd0);
    run_op("nop_wait", 2, 32'h0080_0000, 2);
    i_nop = 1'b0;

    // Store acked while keep is high for two cycles
    drive(32'hCAFE_0001, 32'd0, 5'd7, 1'b1, WBSEL_ALU, MEMRW_NONE, DSIZE_W, mk(OP_ALU, 3'b000));
    push_exp("pre_keep", 32'hCAFE_0001, 5'd7, 1'b1, mk(OP_ALU, 3'b000));
    run_op("pre_keep", 0, 32'd0, 0);
    drive(32'h0000_2000, 32'h1234_5678, 5'd0, 1'b0, WBSEL_ALU, MEMRW_STORE, DSIZE_W, mk(OP_STORE, 3'b010));
    push_exp("st_keep", 32'h0000_2000, 5'd0, 1'b0, mk(OP_STORE, 3'b010));
    i_keep = 1'b1; i_dmem_ack = 1'b1; hs = 0;
    for (int c = 0; c < 3; c++) begin
      if (c == 1) i_dmem_ack = 1'b0;
      if (c == 2) i_keep = 1'b0;
      #2;
      if (o_dmem_req && i_dmem_ack) hs++;
      if (c == 0) check_eq("st_keep.stall_ack", 32'(o_stall_mem), 32'd0);
      else begin
        check_eq($sformatf("st_keep.hold_stall%0d", c), 32'(o_stall_mem), 32'd1);
        check_eq($sformatf("st_keep.hold_req%0d", c), 32'(o_dmem_req), 32'd0);
      end
      check_eq($sformatf("st_keep.held%0d", c), o_WB_data_pype3, 32'hCAFE_0001);
      @(posedge i_clk); #1;
    end
    check_eq("st_keep.handshakes", 32'(hs), 32'd1);
    sb_check("st_keep");

    // Timeout: no ack at all
    drive(32'h0000_3000, 32'd0, 5'd9, 1'b1, WBSEL_MEM, MR_LOAD, DSIZE_W, mk(OP_LOAD, F3_LW));
    push_exp("timeout", 32'd0, 5'd0, 1'b0, 32'd0);
    nfault = 0; fault_cyc = -1;
    for (int c = 0; c < 24; c++) begin
      #2;
      if (o_mem_fault) begin
        nfault++;
        fault_cyc = c;
      end
      @(posedge i_clk); #1;
      if (fault_cyc >= 0) break;
    end
    drive(32'h0000_0055, 32'd0, 5'd2, 1'b1, WBSEL_ALU, MEMRW_NONE, DSIZE_W, mk(OP_ALU, 3'b000));
    #2;
    check_eq("timeout.fault_count", 32'(nfault), 32'd1);
    check_eq("timeout.fault_cycle", 32'(fault_cyc), 32'(WAIT_MAX));
    check_eq("timeout.fault_clear", 32'(o_mem_fault), 32'd0);
    sb_check("timeout");
    push_exp("post_to", 32'h0000_0055, 5'd2, 1'b1, mk(OP_ALU, 3'b000));
    run_op("post_to", 0, 32'd0, 0);

    // Reset while waiting
    drive(32'h0000_3004, 32'd0, 5'd9, 1'b1, WBSEL_MEM, MR_LOAD, DSIZE_W, mk(OP_LOAD, F3_LW));
    repeat (3) begin
      @(posedge i_clk); #1;
    end
    i_rst = 1'b1;
    #2;
    check_eq("rst_wait.req_same_cycle", 32'(o_dmem_req), 32'd0);
    check_eq("rst_wait.stall_same_cycle", 32'(o_stall_mem), 32'd0);
    @(posedge i_clk); #3;
    check_eq("rst_wait.wb_data", o_WB_data_pype3, 32'd0);
    check_eq("rst_wait.wreg", 32'(o_WReg_pype3), 32'd0);
    check_eq("rst_wait.regwrite", 32'(o_RegWrite_pype3), 32'd0);
    check_eq("rst_wait.instr", o_Instraction_pype3, 32'd0);
    check_eq("rst_wait.fault", 32'(o_mem_fault), 32'd0);
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    drive(32'h0000_0077, 32'd0, 5'd3, 1'b1, WBSEL_ALU, MEMRW_NONE, DSIZE_W, mk(OP_ALU, 3'b000));
    push_exp("post_rst", 32'h0000_0077, 5'd3, 1'b1, mk(OP_ALU, 3'b000));
    run_op("post_rst", 0, 32'd0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
